audio_frame_buffer: RTL

AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

---
 rtl/audio_frame_buffer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/audio_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_frame_buffer                                            |
// | Purpose  : ping-pong frame buffer, decimated audio in, framed stream out |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module audio_frame_buffer #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] audio_in,
  input  logic             audio_sample_valid,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid_out,
  output logic             sample_last_out,
  input  logic             sample_ready_in,
  output logic [7:0]       frame_count_out,
  output logic             overflow_out,
  input  logic             clear_overflow_in
);

  localparam int            AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;
  localparam logic [1:0] BANK_READING = 2'd3;

  localparam logic [0:0] WR_FILL = 1'b0;
  localparam logic [0:0] WR_WAIT = 1'b1;

  localparam logic [1:0] RD_IDLE     = 2'd0;
  localparam logic [1:0] RD_PREFETCH = 2'd1;
  localparam logic [1:0] RD_STREAM   = 2'd2;

  logic [WIDTH-1:0] mem_a [FRAME_LEN];
  logic [WIDTH-1:0] mem_b [FRAME_LEN];

  logic [1:0][1:0]  bank_q, bank_d;
  logic [0:0]       wr_mode_q, wr_mode_d;
  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic             last_full_q, last_full_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [AW-1:0]    fetch_idx_q, fetch_idx_d;
  logic             fetch_done_q, fetch_done_d;
  logic             mem_vld_q, mem_vld_d;
  logic             mem_last_q, mem_last_d;
  logic [WIDTH-1:0] mem_data_q;
  logic             out_vld_q, out_vld_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic wr_en, drop, issue, move, full0, full1, sel;

  always_comb begin
    bank_d        = bank_q;
    wr_mode_d     = wr_mode_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    last_full_d   = last_full_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    drop          = 1'b0;

    // In WR_WAIT, wr_bank_q already names the next bank; it is claimed once EMPTY.
    if (wr_mode_q == WR_FILL) begin
      if (audio_sample_valid) begin
        wr_en    = 1'b1;
        wr_idx_d = wr_idx_q + AW'(1);
        if (wr_idx_q == LAST_IDX) begin
          bank_d[wr_bank_q] = BANK_FULL;
          wr_mode_d         = WR_WAIT;
          wr_bank_d         = ~wr_bank_q;
          last_full_d       = wr_bank_q;
          frame_count_d     = frame_count_q + 8'd1;
        end
      end
    end else if (bank_q[wr_bank_q] == BANK_EMPTY) begin
      bank_d[wr_bank_q] = BANK_FILLING;
      wr_mode_d         = WR_FILL;
      if (audio_sample_valid) begin
        wr_en    = 1'b1;
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end else if (audio_sample_valid) begin
      drop = 1'b1;
    end

    overflow_d = (overflow_q & ~clear_overflow_in) | drop;

    full0 = (bank_q[0] == BANK_FULL);
    full1 = (bank_q[1] == BANK_FULL);
    sel   = (full0 && full1) ? ~last_full_q : full1;

    // Two-stage read pipeline: registered memory read, then the output register.
    move  = mem_vld_q && (!out_vld_q || sample_ready_in);
    issue = ((rd_state_q == RD_PREFETCH) || ((rd_state_q == RD_STREAM) && !fetch_done_q))
            && (!mem_vld_q || move);

    fetch_idx_d  = fetch_idx_q;
    fetch_done_d = fetch_done_q;
    if (issue) begin
      fetch_idx_d  = fetch_idx_q + AW'(1);
      fetch_done_d = (fetch_idx_q == LAST_IDX);
    end
    mem_vld_d  = issue || (mem_vld_q && !move);
    mem_last_d = issue ? (fetch_idx_q == LAST_IDX) : mem_last_q;

    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;
    if (move) begin
      out_vld_d  = 1'b1;
      out_last_d = mem_last_q;
      out_data_d = mem_data_q;
    end else if (out_vld_q && sample_ready_in) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (full0 || full1) begin
          bank_d[sel]  = BANK_READING;
          rd_bank_d    = sel;
          fetch_idx_d  = '0;
          fetch_done_d = 1'b0;
          rd_state_d   = RD_PREFETCH;
        end
      end
      RD_PREFETCH: rd_state_d = RD_STREAM;
      RD_STREAM: begin
        if (out_vld_q && sample_ready_in && out_last_q) begin
          bank_d[rd_bank_q] = BANK_EMPTY;
          if (bank_q[~rd_bank_q] == BANK_FULL) begin
            bank_d[~rd_bank_q] = BANK_READING;
            rd_bank_d          = ~rd_bank_q;
            fetch_idx_d        = '0;
            fetch_done_d       = 1'b0;
            rd_state_d         = RD_PREFETCH;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      if (wr_bank_q) mem_b[wr_idx_q] <= audio_in;
      else           mem_a[wr_idx_q] <= audio_in;
    end
    if (issue) mem_data_q <= rd_bank_q ? mem_b[fetch_idx_q] : mem_a[fetch_idx_q];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank_q[0]     <= BANK_FILLING;
      bank_q[1]     <= BANK_EMPTY;
      wr_mode_q     <= WR_FILL;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      last_full_q   <= 1'b0;
      frame_count_q <= 8'd0;
      overflow_q    <= 1'b0;
      rd_state_q    <= RD_IDLE;
      rd_bank_q     <= 1'b0;
      fetch_idx_q   <= '0;
      fetch_done_q  <= 1'b0;
      mem_vld_q     <= 1'b0;
      mem_last_q    <= 1'b0;
      out_vld_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
    end else begin
      bank_q        <= bank_d;
      wr_mode_q     <= wr_mode_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      last_full_q   <= last_full_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      rd_state_q    <= rd_state_d;
      rd_bank_q     <= rd_bank_d;
      fetch_idx_q   <= fetch_idx_d;
      fetch_done_q  <= fetch_done_d;
      mem_vld_q     <= mem_vld_d;
      mem_last_q    <= mem_last_d;
      out_vld_q     <= out_vld_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
    end
  end

  assign sample_out       = out_data_q;
  assign sample_valid_out = out_vld_q;
  assign sample_last_out  = out_last_q;
  assign frame_count_out  = frame_count_q;
  assign overflow_out     = overflow_q;

endmodule
`default_nettype wire
